// File: rtl/qpsk_bit_packer.sv
// QPSK bit packer: collects 2-bit demapped symbols MSB-first into OUT_W-bit words,
// closes a word early at frame end (zero-padded, flagged last), and buffers finished
// words in a 2-entry FIFO. A word arriving at a full FIFO with no pop is dropped and
// raises a sticky overflow flag.
module qpsk_bit_packer #(
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned SYM_PER_FRAME = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [1:0]       in_qpsk,
  output logic [OUT_W-1:0] out_word,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  output logic             overflow
);

  localparam int unsigned SymPerWord = OUT_W / 2;
  localparam int unsigned WcW = (SymPerWord > 1) ? $clog2(SymPerWord) : 1;
  localparam int unsigned FcW = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;

  // Packer state
  logic [WcW-1:0]   wcnt_q, wcnt_d;
  logic [FcW-1:0]   fcnt_q, fcnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;

  // FIFO state: head feeds the outputs directly, tail holds the second entry
  logic [OUT_W-1:0] head_word_q, head_word_d;
  logic             head_last_q, head_last_d;
  logic [OUT_W-1:0] tail_word_q, tail_word_d;
  logic             tail_last_q, tail_last_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             word_full;
  logic             frame_end;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] acc_ins;
  int unsigned      shamt;

  // Symbol insertion, word completion and counter advance
  always_comb begin
    word_full = (wcnt_q == WcW'(SymPerWord - 1));
    frame_end = (fcnt_q == FcW'(SYM_PER_FRAME - 1));
    shamt     = (SymPerWord - 1 - 32'(wcnt_q)) * 2;
    acc_ins   = acc_q | (OUT_W'(in_qpsk) << shamt);
    push      = in_vld & (word_full | frame_end);
    wcnt_d    = wcnt_q;
    fcnt_d    = fcnt_q;
    acc_d     = acc_q;
    if (in_vld) begin
      wcnt_d = push ? '0 : wcnt_q + 1'b1;
      fcnt_d = frame_end ? '0 : fcnt_q + 1'b1;
      acc_d  = push ? '0 : acc_ins;
    end
  end

  // FIFO next state; simultaneous push and pop always both succeed
  always_comb begin
    pop         = (cnt_q != 2'd0) & out_rdy;
    head_word_d = head_word_q;
    head_last_d = head_last_q;
    tail_word_d = tail_word_q;
    tail_last_d = tail_last_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    case ({push, pop})
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_word_d = acc_ins;
          head_last_d = frame_end;
        end else begin
          head_word_d = tail_word_q;
          head_last_d = tail_last_q;
          tail_word_d = acc_ins;
          tail_last_d = frame_end;
        end
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_word_d = acc_ins;
          head_last_d = frame_end;
          cnt_d       = 2'd1;
        end else if (cnt_q == 2'd1) begin
          tail_word_d = acc_ins;
          tail_last_d = frame_end;
          cnt_d       = 2'd2;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_word_d = tail_word_q;
          head_last_d = tail_last_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      acc_q       <= '0;
      head_word_q <= '0;
      head_last_q <= 1'b0;
      tail_word_q <= '0;
      tail_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      ovf_q       <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      fcnt_q      <= fcnt_d;
      acc_q       <= acc_d;
      head_word_q <= head_word_d;
      head_last_q <= head_last_d;
      tail_word_q <= tail_word_d;
      tail_last_q <= tail_last_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Outputs straight from the FIFO head registers
  always_comb begin
    out_word = head_word_q;
    out_last = head_last_q;
    out_vld  = (cnt_q != 2'd0);
    overflow = ovf_q;
  end

endmodule
